// File: rtl/demux_1x4_stream_router.sv
// Buffered 1-to-4 stream router: 2-entry FIFO feeding a demux.
// Destination comes from in_dest or a round-robin pointer.
module demux_1x4_stream_router #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_en,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [2];
  logic [1:0]       dst [2];
  logic             rd;
  logic             wr;
  logic             push;
  logic             pop;
  logic             empty;
  logic [1:0]       level_nxt;
  logic [1:0]       dest_in;

  assign empty   = (level == 2'd0);
  assign dest_in = rr_en ? rr_ptr : in_dest;
  assign push    = in_valid & in_ready;
  assign pop     = ~empty & out_ready[dst[rd]];

  always_comb begin
    out_data  = '0;
    out_sel   = '0;
    out_valid = '0;
    if (!empty) begin
      out_data  = mem[rd];
      out_sel   = dst[rd];
      out_valid = 4'b0001 << dst[rd];
    end
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 2'd1;
      2'b01:   level_nxt = level - 2'd1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      dst[0]   <= '0;
      dst[1]   <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      level    <= '0;
      rr_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr] <= in_data;
        dst[wr] <= dest_in;
        wr      <= ~wr;
        if (rr_en) rr_ptr <= rr_ptr + 2'd1;
      end
      if (pop) rd <= ~rd;
      level <= level_nxt;
      // registered so out_ready never reaches in_ready combinationally
      in_ready <= (level_nxt != 2'd2);
    end
  end

endmodule

// File: tb/tb_demux_1x4_stream_router.sv
// Bench for demux_1x4_stream_router.
// Directed pushes feed a scoreboard; a monitor pops on each handshake.
module tb_demux_1x4_stream_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_valid;
  logic       in_ready;
  logic       rr_en;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;
  logic [1:0] level;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb [$];
  logic [1:0] model_rr = 2'd0;

  demux_1x4_stream_router #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready),
    .rr_en(rr_en),
    .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .rr_ptr(rr_ptr), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d,
                      input logic [1:0] dest,
                      input bit rr,
                      output bit acc);
    in_data  = d;
    in_dest  = dest;
    rr_en    = rr;
    in_valid = 1'b1;
    acc      = in_ready;
    if (acc) begin
      sb.push_back({(rr ? model_rr : dest), d});
      if (rr) model_rr = model_rr + 2'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor: sample well after the driving negedge, before the posedge
  always @(negedge clk) begin
    logic [9:0] e;
    #2;
    if (rst_n) begin
      if (out_valid == 4'd0) begin
        chk("idle_data", out_data, 0);
        chk("idle_sel", out_sel, 0);
      end else begin
        chk("onehot", out_valid, 4'b0001 << out_sel);
        if (out_ready[out_sel]) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_word observed=%0h expected=none",
                   {out_sel, out_data});
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_sel", out_sel, e[9:8]);
            chk("out_data", out_data, e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    rst_n     = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    in_valid  = 1'b0;
    rr_en     = 1'b0;
    out_ready = '0;

    // 1: reset state and in_ready rise
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_rr_ptr", rr_ptr, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1);

    // 2: directed dest=2
    out_ready = 4'b0100;
    push(8'hA5, 2'd2, 1'b0, acc);
    in_valid = 1'b0;
    chk("t2_acc", acc, 1);
    chk("t2_sel", out_sel, 2);
    chk("t2_valid", out_valid, 4'b0100);
    chk("t2_data", out_data, 8'hA5);
    chk("t2_level1", level, 1);
    @(negedge clk);
    chk("t2_level0", level, 0);

    // 3: round robin, in_dest ignored, full throughput
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), 2'd3, 1'b1, acc);
      chk("t3_acc", acc, 1);
      chk("t3_rr_ptr", rr_ptr, model_rr);
    end
    idle(3);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_level", level, 0);

    // 4: fill, overflow attempt, drain
    out_ready = 4'h0;
    push(8'h11, 2'd0, 1'b0, acc);
    push(8'h22, 2'd1, 1'b0, acc);
    chk("t4_level_full", level, 2);
    chk("t4_in_ready", in_ready, 0);
    push(8'h33, 2'd2, 1'b0, acc);
    chk("t4_third_acc", acc, 0);
    chk("t4_level_hold", level, 2);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    idle(3);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_level0", level, 0);

    // 5: head-of-line blocking on dest 1
    out_ready = 4'b1101;
    push(8'h5C, 2'd1, 1'b0, acc);
    push(8'h77, 2'd3, 1'b0, acc);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_sel", out_sel, 1);
      chk("t5_data", out_data, 8'h5C);
      chk("t5_level", level, 2);
      @(negedge clk);
    end
    out_ready = 4'hF;
    idle(3);
    chk("t5_sb_empty", sb.size(), 0);

    // 6: async reset while full
    out_ready = 4'h0;
    push(8'hC1, 2'd0, 1'b1, acc);
    push(8'hC2, 2'd0, 1'b1, acc);
    in_valid = 1'b0;
    chk("t6_level_full", level, 2);
    chk("t6_rr_nonzero", rr_ptr, model_rr);
    #4 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_rr_ptr", rr_ptr, 0);
    chk("t6_in_ready", in_ready, 0);
    sb.delete();
    model_rr = 2'd0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 4'hF;
    idle(4);
    chk("t6_after_level", level, 0);
    chk("t6_after_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
